// File: rtl/gelato_wb_queue.sv
// Writeback staging queue: buffers one execution unit's results in order for the writeback arbiter.
// Head is visible one cycle after push (no bypass); in_ready drops only when full or rdy=0.

module gelato_wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Payload storage carries no reset; validity comes from count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_dat = mem[rd_ptr];
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
endmodule

module gelato_wb_queue #(
  parameter int DEPTH      = 4,
  parameter int THREADS    = 32,
  parameter int WARP_ID_W  = 5,
  parameter int REG_ADDR_W = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rdy,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WARP_ID_W-1:0]      in_warp_id,
  input  logic [REG_ADDR_W-1:0]     in_rd,
  input  logic [THREADS-1:0]        in_mask,
  input  logic [THREADS*32-1:0]     in_data,
  output logic                      wb_valid,
  input  logic                      wb_grant,
  output logic [WARP_ID_W-1:0]      wb_warp_id,
  output logic [REG_ADDR_W-1:0]     wb_rd,
  output logic [THREADS-1:0]        wb_mask,
  output logic [THREADS*32-1:0]     wb_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [WARP_ID_W-1:0]  warp_id;
    logic [REG_ADDR_W-1:0] rd;
    logic [THREADS-1:0]    mask;
    logic [THREADS*32-1:0] data;
  } wb_entry_t;

  wb_entry_t push_ent;
  wb_entry_t head_ent;
  logic      empty;
  logic      push_acc;
  logic      store;
  logic      pop;

  assign push_ent = '{warp_id: in_warp_id, rd: in_rd, mask: in_mask, data: in_data};

  // in_ready depends only on held state and rdy, never on wb_grant.
  assign in_ready = rdy && !full && rst_n;
  assign wb_valid = rdy && !empty;
  assign push_acc = in_valid && in_ready;
  // Results with no active lanes or targeting x0 are consumed but never written back.
  assign store    = push_acc && (in_mask != '0) && (in_rd != '0);
  assign pop      = wb_valid && wb_grant;

  gelato_wb_fifo #(
    .WIDTH ($bits(wb_entry_t)),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (store),
    .push_dat (push_ent),
    .pop      (pop),
    .head_dat (head_ent),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  assign wb_warp_id = empty ? '0 : head_ent.warp_id;
  assign wb_rd      = empty ? '0 : head_ent.rd;
  assign wb_mask    = empty ? '0 : head_ent.mask;
  assign wb_data    = empty ? '0 : head_ent.data;
endmodule

// File: tb/tb_gelato_wb_queue.sv
// Bench for gelato_wb_queue: directed plan steps plus random traffic against a queue-based model.
module tb_gelato_wb_queue;
  localparam int DEPTH = 4;
  localparam int THREADS = 32;
  localparam int DW = THREADS * 32;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rdy = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [4:0]    in_warp_id = '0;
  logic [4:0]    in_rd = '0;
  logic [31:0]   in_mask = '0;
  logic [DW-1:0] in_data = '0;
  logic          wb_valid;
  logic          wb_grant = 1'b0;
  logic [4:0]    wb_warp_id;
  logic [4:0]    wb_rd;
  logic [31:0]   wb_mask;
  logic [DW-1:0] wb_data;
  logic [CW-1:0] count;
  logic          full;

  gelato_wb_queue #(.DEPTH(DEPTH), .THREADS(THREADS), .WARP_ID_W(5), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .in_valid(in_valid), .in_ready(in_ready), .in_warp_id(in_warp_id), .in_rd(in_rd),
    .in_mask(in_mask), .in_data(in_data),
    .wb_valid(wb_valid), .wb_grant(wb_grant), .wb_warp_id(wb_warp_id), .wb_rd(wb_rd),
    .wb_mask(wb_mask), .wb_data(wb_data), .count(count), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]    warp;
    logic [4:0]    rd;
    logic [31:0]   mask;
    logic [DW-1:0] data;
  } ent_t;

  ent_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_data(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed low64 %0h expected low64 %0h", tag, obs[63:0], exp[63:0]);
    end
  endtask

  // Expected outputs follow from the model queue and the current rdy/rst_n.
  task automatic check_outputs(input string tag);
    int n;
    ent_t h;
    n = q.size();
    h = '{warp: '0, rd: '0, mask: '0, data: '0};
    if (n != 0) h = q[0];
    chk({tag, ".count"},    64'(count),    64'(n));
    chk({tag, ".full"},     64'(full),     64'(n == DEPTH));
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(rdy && rst_n && n != DEPTH));
    chk({tag, ".wb_valid"}, 64'(wb_valid), 64'(rdy && n != 0));
    chk({tag, ".wb_warp"},  64'(wb_warp_id), 64'(h.warp));
    chk({tag, ".wb_rd"},    64'(wb_rd),    64'(h.rd));
    chk({tag, ".wb_mask"},  64'(wb_mask),  64'(h.mask));
    chk_data({tag, ".wb_data"}, wb_data, h.data);
  endtask

  // One cycle: drive at negedge, check before the edge, update the model on the edge.
  task automatic step(input string tag, input logic v, input logic [4:0] w, input logic [4:0] r,
                      input logic [31:0] m, input logic [DW-1:0] d, input logic g, input logic ry);
    logic acc, do_pop;
    ent_t e;
    in_valid = v; in_warp_id = w; in_rd = r; in_mask = m; in_data = d;
    wb_grant = g; rdy = ry;
    #1;
    check_outputs(tag);
    acc    = v && ry && (q.size() != DEPTH);
    do_pop = g && ry && (q.size() != 0);
    e = '{warp: w, rd: r, mask: m, data: d};
    @(posedge clk);
    if (do_pop) void'(q.pop_front());
    if (acc && m != 0 && r != 0) q.push_back(e);
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < THREADS; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  task automatic idle(input string tag, input logic g, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 5'd0, 5'd0, 32'd0, '0, g, 1'b1);
  endtask

  task automatic push(input string tag, input logic [4:0] r, input logic g);
    step(tag, 1'b1, 5'($urandom), r, $urandom | 32'h1, rand_data(), g, 1'b1);
  endtask

  initial begin
    logic [DW-1:0] d;
    rdy = 1'b1;
    #1;
    check_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single push, head holds without grant
    d = '0;
    d[31:0] = 32'h11;
    step("t1_push", 1'b1, 5'd3, 5'd7, 32'hFFFF_FFFF, d, 1'b0, 1'b1);
    idle("t1_hold", 1'b0, 5);
    idle("t1_drain", 1'b1, 1);

    // 2: fill to full, fifth push refused, drain in order
    for (int i = 1; i <= 4; i++) push("t2_fill", 5'(i), 1'b0);
    push("t2_fifth", 5'd9, 1'b0);
    idle("t2_drain", 1'b1, 4);
    idle("t2_empty", 1'b0, 1);

    // 3: concurrent push/pop with two queued, then while full
    push("t3_a", 5'd10, 1'b0);
    push("t3_b", 5'd11, 1'b0);
    push("t3_pp", 5'd12, 1'b1);
    push("t3_c", 5'd13, 1'b0);
    push("t3_d", 5'd14, 1'b0);
    push("t3_fullpp", 5'd15, 1'b1);
    idle("t3_drain", 1'b1, 4);

    // 4: discarded pushes
    step("t4_mask0", 1'b1, 5'd1, 5'd6, 32'd0, rand_data(), 1'b0, 1'b1);
    step("t4_rd0", 1'b1, 5'd2, 5'd0, 32'hFFFF_FFFF, rand_data(), 1'b0, 1'b1);
    idle("t4_after", 1'b0, 2);

    // 5: rdy low freezes everything
    for (int i = 1; i <= 3; i++) push("t5_fill", 5'(20 + i), 1'b0);
    for (int i = 0; i < 4; i++)
      step("t5_frozen", 1'b1, 5'd1, 5'd30, 32'h1, rand_data(), 1'b1, 1'b0);
    idle("t5_resume", 1'b1, 4);

    // 6: asynchronous reset mid-cycle discards queued entries
    for (int i = 1; i <= 3; i++) push("t6_fill", 5'(24 + i), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    check_outputs("t6_async");
    @(negedge clk);
    check_outputs("t6_held");
    rst_n = 1'b1;
    idle("t6_post", 1'b0, 1);
    push("t6_new", 5'd31, 1'b0);
    idle("t6_alone", 1'b1, 2);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step("rand",
           1'($urandom_range(0, 3) != 0),
           5'($urandom),
           ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
           ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom),
           rand_data(),
           1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 9) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/gelato_wb_queue.md
Name: gelato_wb_queue

Overview:
- Per-execution-unit writeback staging queue. It is the transmitting end of the writeback channel that the top-level round-robin writeback arbiter receives.
- Buffers completed results from one execution unit (compute, load/store, tensor) and presents the oldest result on the wb_valid/wb_grant handshake.
- Holds each result until the arbiter grants it, so execution units never stall on arbitration unless the queue is full.
- One instance per execution unit, between the unit's result stage and the arbiter port.

Parameters:
DEPTH, 4, number of queued writeback entries (power of two, >= 2)
THREADS, 32, lanes per warp
WARP_ID_W, 5, warp index width
REG_ADDR_W, 5, destination register index width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
rdy  input  1  global enable; when 0 the block freezes
in_valid  input  1  execution unit presents a result
in_ready  output  1  queue accepts a result this cycle
in_warp_id  input  WARP_ID_W  warp of the result
in_rd  input  REG_ADDR_W  destination register
in_mask  input  THREADS  active-lane write mask
in_data  input  THREADS*32  per-lane results, lane i at bits [32i+31:32i]
wb_valid  output  1  head entry offered to the arbiter
wb_grant  input  1  arbiter consumes the head entry this cycle
wb_warp_id  output  WARP_ID_W  head warp
wb_rd  output  REG_ADDR_W  head destination register
wb_mask  output  THREADS  head lane mask
wb_data  output  THREADS*32  head data
count  output  $clog2(DEPTH)+1  occupancy
full  output  1  count == DEPTH

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: count=0, full=0, wb_valid=0, in_ready=0 while rst_n=0. wb_warp_id, wb_rd, wb_mask and wb_data are 0 while empty. Read/write pointers are 0.
- Reset mid-operation: every queued entry is discarded immediately. Nothing is offered after rst_n deasserts until a new push.
- Handshake conditions:
  - in_ready = rdy && !full. It is registered-state-derived, with no combinational path from wb_grant.
  - Push occurs when in_valid && in_ready.
  - Pop occurs when wb_valid && wb_grant.
  - wb_valid = rdy && (count != 0).
- Discard rule: a push with in_mask == 0, or with in_rd == 0 (x0), is accepted (in_ready honoured) but not stored. count does not change.
- Latency: an entry pushed in cycle N is visible on wb_* at cycle N+1 at the earliest. There is no same-cycle bypass.
- FIFO order:
  - Outputs show the head entry combinationally from storage and stay stable while wb_valid=1 and no pop occurs.
  - Entries leave in push order.
  - Pointers wrap modulo DEPTH.
- Simultaneous push and pop (queue non-empty, not full): both happen and count is unchanged.
  - When full, in_ready=0, so no push occurs even if a pop happens the same cycle. The freed slot becomes available next cycle.
- Empty with push in the same cycle: no pop is possible (wb_valid=0). The entry appears next cycle.
- Grant handling:
  - A wb_grant with wb_valid=0 is ignored.
  - A grant held high for several cycles pops one entry per cycle while entries remain.
- rdy=0: no push, no pop, in_ready=0, wb_valid=0. Storage, pointers and count are held. Operation resumes unchanged when rdy returns to 1.
- count arithmetic: count increments on a stored push, decrements on a pop, and never exceeds DEPTH or goes below 0. full = (count == DEPTH).

Test Plan:
1. Reset, then push {warp=3, rd=7, mask=0xFFFFFFFF, lane0=0x11} at cycle 1 with wb_grant=0 -> wb_valid=1 at cycle 2 with the same fields; count=1; the fields hold for 5 cycles without a grant.
2. Push 4 entries with rd=1..4 and grant held 0 -> full=1, in_ready=0, a fifth in_valid is not accepted. Then grant for 4 cycles -> wb_rd sequence is 1,2,3,4, then wb_valid=0 and count=0.
3. With 2 entries queued, push and grant in the same cycle -> count stays 2 and order is preserved. When full, push and grant together -> count becomes 3 and the push is not accepted.
4. Push with mask=0, then with rd=0 -> in_ready=1 both cycles, count stays 0, wb_valid never asserts.
5. With 3 entries queued, drop rdy for 4 cycles while grant=1 and in_valid=1 -> wb_valid=0, in_ready=0, count=3 throughout. After rdy=1, pops resume with the original head.
6. With 3 entries queued, pulse rst_n low mid-cycle -> wb_valid and count go to 0 asynchronously. After release, the first new push appears alone, with no stale entries.
